// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with active-low request/grant.
// The owner keeps the bus while it requests; on release the bus is handed
// straight to the next requester at the same edge. An optional hold-time
// watchdog revokes the grant from a master that owns the bus too long.
//
// Handshake: a master asks for the bus by holding MReq_[i] low and owns it
// for every cycle in which MGrnt_[i] is low; it gives the bus up by driving
// MReq_[i] high, and its grant goes high at the next rising edge.
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] MReq_,
  output logic [3:0] MGrnt_,
  output logic [1:0] Owner,
  output logic       Busy,
  output logic       Timeout,
  output logic [1:0] TimeoutId
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Watchdog fires when the hold counter reaches HOLD_MAX-1 (owner has had
  // the bus for HOLD_MAX cycles). HOLD_MAX of zero turns the watchdog off.
  localparam bit       WD_EN     = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST = WD_EN ? 8'(HOLD_MAX - 1) : 8'd0;

  state_t     state_q, state_nxt;
  logic [3:0] grant_q, grant_nxt;
  logic [1:0] owner_q, owner_nxt;
  logic [1:0] last_q, last_nxt;
  logic [7:0] hold_q, hold_nxt;
  logic       timeout_q, timeout_nxt;
  logic [1:0] tid_q, tid_nxt;
  logic [2:0] pick;

  // Round-robin search: first requesting master after start_after, wrapping
  // upward; start_after itself is checked last. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_n,
                                         input logic [1:0] start_after);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = start_after + 2'(k);
      if (!req_n[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q   <= IDLE;
      grant_q   <= 4'b1111;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
      tid_q     <= 2'd0;
    end else begin
      state_q   <= state_nxt;
      grant_q   <= grant_nxt;
      owner_q   <= owner_nxt;
      last_q    <= last_nxt;
      hold_q    <= hold_nxt;
      timeout_q <= timeout_nxt;
      tid_q     <= tid_nxt;
    end
  end

  // Next-state logic: grant from idle, hand over on release, watchdog revoke.
  always_comb begin
    state_nxt   = state_q;
    grant_nxt   = grant_q;
    owner_nxt   = owner_q;
    last_nxt    = last_q;
    hold_nxt    = hold_q;
    timeout_nxt = 1'b0;
    tid_nxt     = tid_q;
    pick        = 3'b000;
    case (state_q)
      IDLE: begin
        pick = rr_pick(MReq_, last_q);
        if (pick[2]) begin
          grant_nxt = ~(4'b0001 << pick[1:0]);
          owner_nxt = pick[1:0];
          hold_nxt  = 8'd0;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        if (MReq_[owner_q]) begin
          // Owner released: its own request is high, so the search naturally
          // skips it and lands on the next requester if there is one.
          last_nxt = owner_q;
          pick     = rr_pick(MReq_, owner_q);
          if (pick[2]) begin
            grant_nxt = ~(4'b0001 << pick[1:0]);
            owner_nxt = pick[1:0];
            hold_nxt  = 8'd0;
          end else begin
            grant_nxt = 4'b1111;
            state_nxt = IDLE;
          end
        end else if (WD_EN && (hold_q == HOLD_LAST)) begin
          // Revoke; recording the owner as last gives it lowest priority.
          grant_nxt   = 4'b1111;
          timeout_nxt = 1'b1;
          tid_nxt     = owner_q;
          last_nxt    = owner_q;
          state_nxt   = IDLE;
        end else if (hold_q != 8'hFF) begin
          hold_nxt = hold_q + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b1111;
      end
    endcase
  end

  assign MGrnt_    = grant_q;
  assign Owner     = owner_q;
  assign Busy      = (state_q == OWNED);
  assign Timeout   = timeout_q;
  assign TimeoutId = tid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: three instances share clock and reset,
// one at the default hold limit, one with HOLD_MAX=4, one with the
// watchdog disabled.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic [3:0] req_a = 4'b1111, req_b = 4'b1111, req_c = 4'b1111;
  logic [3:0] a_grant, b_grant, c_grant;
  logic [1:0] a_owner, b_owner, c_owner;
  logic       a_busy, b_busy, c_busy;
  logic       a_to, b_to, c_to;
  logic [1:0] a_tid, b_tid, c_tid;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.HOLD_MAX(16)) u_a (
    .clk(clk), .reset_(reset_), .MReq_(req_a), .MGrnt_(a_grant),
    .Owner(a_owner), .Busy(a_busy), .Timeout(a_to), .TimeoutId(a_tid));

  bus_arbiter #(.HOLD_MAX(4)) u_b (
    .clk(clk), .reset_(reset_), .MReq_(req_b), .MGrnt_(b_grant),
    .Owner(b_owner), .Busy(b_busy), .Timeout(b_to), .TimeoutId(b_tid));

  bus_arbiter #(.HOLD_MAX(0)) u_c (
    .clk(clk), .reset_(reset_), .MReq_(req_c), .MGrnt_(c_grant),
    .Owner(c_owner), .Busy(c_busy), .Timeout(c_to), .TimeoutId(c_tid));

  // Clock generation
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    req_a = 4'b1111; req_b = 4'b1111; req_c = 4'b1111;
    step(); step();
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    req_a = 4'b1111; req_b = 4'b1111; req_c = 4'b1111;
    step(); step();
    vectors++;
    if (a_grant !== 4'b1111 || a_owner !== 2'd0 || a_busy !== 1'b0 ||
        a_to !== 1'b0 || a_tid !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: grant=%b owner=%0d busy=%b to=%b tid=%0d want 1111/0/0/0/0",
               a_grant, a_owner, a_busy, a_to, a_tid);
    end
    vectors++;
    if (b_grant !== 4'b1111 || c_grant !== 4'b1111 || b_busy !== 1'b0 || c_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_other: b_grant=%b c_grant=%b want 1111", b_grant, c_grant);
    end
    reset_ = 1'b1;
    req_a = 4'b1101;
    step();
    vectors++;
    if (a_grant !== 4'b1101 || a_owner !== 2'd1 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: grant=%b owner=%0d busy=%b want 1101/1/1",
               a_grant, a_owner, a_busy);
    end
    req_a = 4'b1111;
    step();
    vectors++;
    if (a_grant !== 4'b1111 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: grant=%b busy=%b want 1111/0", a_grant, a_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_o;
    logic [3:0] exp_g;
    do_reset();
    req_a = 4'b0000;
    step();
    for (int n = 0; n < 5; n++) begin
      exp_o = 2'(n);
      exp_g = ~(4'b0001 << exp_o);
      for (int c = 0; c < 3; c++) begin
        vectors++;
        if (a_grant !== exp_g || a_owner !== exp_o || a_busy !== 1'b1 ||
            $countones(~a_grant) > 1) begin
          miscompares++;
          $display("FAIL rr_order n=%0d c=%0d: grant=%b owner=%0d busy=%b want %b/%0d/1",
                   n, c, a_grant, a_owner, a_busy, exp_g, exp_o);
        end
        if (c == 2) req_a[exp_o] = 1'b1;
        step();
        if (c == 2) req_a = 4'b0000;
      end
    end
  endtask

  task automatic test_priority_wrap();
    do_reset();
    req_a = 4'b0111;
    step();
    vectors++;
    if (a_grant !== 4'b0111 || a_owner !== 2'd3) begin
      miscompares++;
      $display("FAIL wrap_m3: grant=%b owner=%0d want 0111/3", a_grant, a_owner);
    end
    req_a = 4'b1010;
    step();
    vectors++;
    if (a_grant !== 4'b1110 || a_owner !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_m0: grant=%b owner=%0d want 1110/0", a_grant, a_owner);
    end
    req_a = 4'b1011;
    step();
    vectors++;
    if (a_grant !== 4'b1011 || a_owner !== 2'd2) begin
      miscompares++;
      $display("FAIL wrap_m2: grant=%b owner=%0d want 1011/2", a_grant, a_owner);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    req_b = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (b_grant !== 4'b1110 || b_to !== 1'b0) begin
        miscompares++;
        $display("FAIL wd_hold c=%0d: grant=%b to=%b want 1110/0", c, b_grant, b_to);
      end
    end
    step();
    vectors++;
    if (b_grant !== 4'b1111 || b_to !== 1'b1 || b_tid !== 2'd0 || b_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_revoke: grant=%b to=%b tid=%0d busy=%b want 1111/1/0/0",
               b_grant, b_to, b_tid, b_busy);
    end
    step();
    vectors++;
    if (b_grant !== 4'b1110 || b_to !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_regrant: grant=%b to=%b want 1110/0", b_grant, b_to);
    end
  endtask

  task automatic test_watchdog_fairness();
    do_reset();
    req_b = 4'b1110;
    step();
    req_b = 4'b1010;
    step(); step(); step();
    vectors++;
    if (b_grant !== 4'b1110 || b_owner !== 2'd0) begin
      miscompares++;
      $display("FAIL wdf_hold: grant=%b owner=%0d want 1110/0", b_grant, b_owner);
    end
    step();
    vectors++;
    if (b_grant !== 4'b1111 || b_to !== 1'b1 || b_tid !== 2'd0) begin
      miscompares++;
      $display("FAIL wdf_revoke: grant=%b to=%b tid=%0d want 1111/1/0", b_grant, b_to, b_tid);
    end
    step();
    vectors++;
    if (b_grant !== 4'b1011 || b_owner !== 2'd2) begin
      miscompares++;
      $display("FAIL wdf_m2_first: grant=%b owner=%0d want 1011/2", b_grant, b_owner);
    end
  endtask

  task automatic test_release_vs_watchdog();
    do_reset();
    req_b = 4'b1110;
    step(); step(); step(); step();
    req_b = 4'b1111;
    step();
    vectors++;
    if (b_grant !== 4'b1111 || b_to !== 1'b0 || b_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rel_wins: grant=%b to=%b busy=%b want 1111/0/0", b_grant, b_to, b_busy);
    end
  endtask

  task automatic test_watchdog_disabled();
    do_reset();
    req_c = 4'b1110;
    for (int c = 0; c < 300; c++) begin
      step();
      vectors++;
      if (c_grant !== 4'b1110 || c_to !== 1'b0) begin
        miscompares++;
        $display("FAIL wd_off c=%0d: grant=%b to=%b want 1110/0", c, c_grant, c_to);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_a = 4'b1011;
    step();
    vectors++;
    if (a_grant !== 4'b1011 || a_owner !== 2'd2) begin
      miscompares++;
      $display("FAIL mid_own: grant=%b owner=%0d want 1011/2", a_grant, a_owner);
    end
    reset_ = 1'b0;
    req_a = 4'b1001;
    step();
    vectors++;
    if (a_grant !== 4'b1111 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: grant=%b busy=%b want 1111/0", a_grant, a_busy);
    end
    reset_ = 1'b1;
    step();
    vectors++;
    if (a_grant !== 4'b1101 || a_owner !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_restart: grant=%b owner=%0d want 1101/1", a_grant, a_owner);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority_wrap();
    test_watchdog();
    test_watchdog_fairness();
    test_release_vs_watchdog();
    test_watchdog_disabled();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared system bus, granting ownership to one of four bus masters. Each master's `bus_if` drives an active-low request and waits for an active-low grant. The arbiter holds the grant while the owner keeps requesting and hands the bus directly to the next requester when the owner releases it. A hold-time watchdog forcibly revokes the grant from a master that keeps the bus too long.

## Interface

Parameters:
- `HOLD_MAX`, default 16 — maximum consecutive cycles one master may own the bus; legal range 0..255; 0 disables the watchdog.

Ports:
- `clk` in 1 — system clock; all state changes on the rising edge.
- `reset_` in 1 — reset; one clock; reset is synchronous and active-low.
- `MReq_` in 4 — per-master bus request, active-low; bit i belongs to master i.
- `MGrnt_` out 4 — per-master bus grant, active-low, registered; at most one bit low at any time.
- `Owner` out 2 — index of the current owner; valid only while `Busy`=1.
- `Busy` out 1 — high while some master holds the grant.
- `Timeout` out 1 — one-cycle pulse when the watchdog revokes a grant.
- `TimeoutId` out 2 — index of the last revoked master; holds its value until the next revoke.

## Operation

- **Reset** (`reset_`=0 at an edge): `MGrnt_`=4'b1111, `Owner`=0, `Busy`=0, `Timeout`=0, `TimeoutId`=0, internal `Last`=3, `HoldCnt`=0, state=IDLE.
- **Priority rule:** search the masters starting from (`Last`+1) mod 4 and wrapping upward. The first master with `MReq_[i]`=0 wins.
- **IDLE** (all grants high):
  - If any request is low, grant the round-robin winner: set `MGrnt_[w]`=0, `Owner`=w, `HoldCnt`=0, go to OWNED.
  - Otherwise stay in IDLE.
- **OWNED** (`MGrnt_[Owner]`=0), evaluated in this order:
  1. **Owner releases** (`MReq_[Owner]`=1):
     - Set `Last`=`Owner`.
     - If another master requests, the search runs from `Owner`+1 and excludes `Owner`. Grant the winner at the same edge (zero dead cycles), reset `HoldCnt`=0, stay in OWNED.
     - Otherwise drive all grants high and go to IDLE.
  2. **Watchdog** (`HOLD_MAX`≠0 and `HoldCnt`==`HOLD_MAX`-1, owner still requesting):
     - Drive all grants high, pulse `Timeout`=1, set `TimeoutId`=`Owner` and `Last`=`Owner`, go to IDLE.
     - The revoked master may win again from IDLE, but with lowest priority.
  3. **Otherwise:** `HoldCnt`+=1, saturating at 255.
- `HoldCnt` is 8 bits.
- `Busy` is 1 exactly when the state is OWNED.
- Requests from masters other than the owner do not affect the current grant.

## Timing

- The request is sampled at edge N; the grant is visible from edge N (registered) for the whole following cycle. From IDLE, request-to-grant latency is 1 cycle.
- **Handover:** the owner deasserts its request in cycle C. Its grant goes high and the next grant goes low at the same edge ending C. The two grants are never low together and there is no idle cycle.
- **Release:** after the owner's request goes high, its grant goes high on the following edge.
- **Watchdog:** with the grant first low in cycle G, revocation is at the edge ending cycle G+`HOLD_MAX`-1. The owner therefore holds the bus for exactly `HOLD_MAX` cycles.
  - `Timeout` is high in cycle G+`HOLD_MAX` only.
  - With `HOLD_MAX`=1, every grant lasts exactly one cycle while requested.
- **Simultaneous release and watchdog expiry:** release wins; no `Timeout` pulse.
- **Reset mid-ownership:** grants go high at the reset edge, and priority restarts at master 0.
- A master that drops its request while it is not the owner has no effect.

## Test plan

- **Reset and single requester:** hold `reset_`=0 for 2 cycles, then `MReq_`=4'b1101.
  - `MGrnt_`=4'b1101 and `Owner`=1 one cycle later.
  - Release the request; `MGrnt_`=4'b1111 and `Busy`=0 one cycle after the release.
- **Round-robin fairness:** after reset, all four masters request continuously and each releases after 3 owned cycles.
  - Grant order is 0,1,2,3,0.
  - Each handover has no gap, and `MGrnt_` never has two bits low.
- **Priority wrap:** master 3 owns the bus, then releases while masters 0 and 2 request.
  - Master 0 is granted next.
  - After master 0 releases, master 2 is granted.
- **Watchdog:** set `HOLD_MAX`=4 and hold `MReq_`=4'b1110 indefinitely.
  - Grant is low for exactly 4 cycles, then `MGrnt_`=4'b1111 with `Timeout`=1 and `TimeoutId`=0 for 1 cycle.
  - Master 0 is re-granted on the next cycle.
- **Watchdog fairness and disable:**
  - With `HOLD_MAX`=4, master 0 is revoked while master 2 is requesting; master 2 is granted out of IDLE before master 0.
  - With `HOLD_MAX`=0, master 0 holds the grant for 300 cycles with no `Timeout`.
- **Reset mid-operation:** assert `reset_`=0 while master 2 owns the bus.
  - `MGrnt_`=4'b1111 at the next edge.
  - After reset, with masters 1 and 2 requesting, master 1 wins.
